moore_seq_detector: RTL and testbench



---
 rtl/moore_seq_detector.sv | 142 ++++++++++++++
 tb/tb_moore_seq_detector.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector.sv
// moore_seq_detector
//   Parametrised Moore serial sequence detector. One bit is consumed per
//   cycle when in_valid is high. The FSM state is the length of the pattern
//   prefix matched so far (0..PAT_W); detect is high while state == PAT_W.
//   Matches are counted in a saturating counter with a sticky saturation flag.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  pattern, MSB received first
//   OVERLAP  1: overlapping matches, 0: restart from state 0 after a match
//   CNT_W    match counter width
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in         serial data bit
//   in_valid   qualifies in
//   clear      synchronous clear of state, counter and saturation flag
//   state      matched-prefix length
//   detect     high while state == PAT_W (registered)
//   match_cnt  saturating match count
//   cnt_sat    sticky flag, set when a match arrives with match_cnt at all-ones
//
// Optional build macro MOORE_SEQ_PATTERN_LOAD_EN adds:
//   pat_load   capture pat_data as the new pattern, state forced to 0
//   pat_data   new pattern value
module moore_seq_detector #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in,
  input  logic                         in_valid,
  input  logic                         clear,
`ifdef MOORE_SEQ_PATTERN_LOAD_EN
  input  logic                         pat_load,
  input  logic [PAT_W-1:0]             pat_data,
`endif
  output logic [$clog2(PAT_W+1)-1:0]   state,
  output logic                         detect,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat
);

  localparam int unsigned SW   = $clog2(PAT_W + 1);
  localparam logic [SW-1:0] FULL = SW'(PAT_W);

  logic [PAT_W-1:0] pat;
  logic             load;
  logic [SW-1:0]    nxt_state;

`ifdef MOORE_SEQ_PATTERN_LOAD_EN
  assign load = pat_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat <= PATTERN;
    end else if (!clear && pat_load) begin
      pat <= pat_data;
    end
  end
`else
  assign load = 1'b0;
  assign pat  = PATTERN;
`endif

  // Next state is the longest pattern prefix that is a suffix of
  // (current matched prefix ++ in). The matched prefix is implied by the
  // state, so the candidate suffix is rebuilt from the pattern itself; this
  // keeps the logic valid for a pattern loaded at run time. In non-overlap
  // mode a full match restarts the search from an empty prefix.
  int unsigned      k;
  int unsigned      m;
  logic             ok;
  logic             sbit;
  logic [PAT_W-1:0] shp;
  logic [PAT_W-1:0] shq;

  always_comb begin
    nxt_state = '0;
    m         = 0;
    ok        = 1'b0;
    sbit      = 1'b0;
    shp       = '0;
    shq       = '0;
    if (!OVERLAP && state == FULL) begin
      k = 0;
    end else begin
      k = 32'(state);
    end
    for (int unsigned j = 1; j <= PAT_W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < PAT_W; i++) begin
          if (i < j) begin
            m    = k + 1 - j + i;
            shp  = pat >> (PAT_W - 1 - m);
            sbit = (m < k) ? shp[0] : in;
            shq  = pat >> (PAT_W - 1 - i);
            if (sbit != shq[0]) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          nxt_state = SW'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= '0;
      detect    <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (clear) begin
      state     <= '0;
      detect    <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (load) begin
      state  <= '0;
      detect <= 1'b0;
    end else if (in_valid) begin
      state  <= nxt_state;
      detect <= (nxt_state == FULL);
      if (nxt_state == FULL) begin
        if (&match_cnt) begin
          cnt_sat <= 1'b1;
        end else begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: two instances sharing stimulus, one
// overlapping with a 2-bit counter (A) and one non-overlapping with an
// 8-bit counter (B). Pattern 1011.
module tb_moore_seq_detector;

  localparam int unsigned PAT_W = 4;
  localparam logic [3:0]  P     = 4'b1011;

  logic       clk;
  logic       reset;
  logic       in;
  logic       in_valid;
  logic       clear;
  logic [2:0] state_a, state_b;
  logic       detect_a, detect_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;
  logic       sat_a, sat_b;
`ifdef MOORE_SEQ_PATTERN_LOAD_EN
  logic       pat_load;
  logic [3:0] pat_data;
`endif

  moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_a (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear),
`ifdef MOORE_SEQ_PATTERN_LOAD_EN
    .pat_load(pat_load), .pat_data(pat_data),
`endif
    .state(state_a), .detect(detect_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear),
`ifdef MOORE_SEQ_PATTERN_LOAD_EN
    .pat_load(pat_load), .pat_data(pat_data),
`endif
    .state(state_b), .detect(detect_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    sa;
    int    ca;
    int    xa;   // expected sat_a, -1 = not checked
    int    sb;
    int    cb;
    string name;
  } exp_t;

  typedef struct {
    logic v;
    logic b;
    logic c;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  bit ha[$];
  bit hb[$];
  int ma_s, ma_c, ma_x, mb_s, mb_c;

  task automatic chk(string nm, integer act, integer expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic compare(exp_t e);
    chk({e.name, ".state_a"},  state_a,  e.sa);
    chk({e.name, ".detect_a"}, detect_a, (e.sa == 4) ? 1 : 0);
    chk({e.name, ".cnt_a"},    cnt_a,    e.ca);
    if (e.xa >= 0) chk({e.name, ".sat_a"}, sat_a, e.xa);
    chk({e.name, ".state_b"},  state_b,  e.sb);
    chk({e.name, ".detect_b"}, detect_b, (e.sb == 4) ? 1 : 0);
    chk({e.name, ".cnt_b"},    cnt_b,    e.cb);
    chk({e.name, ".sat_b"},    sat_b,    0);
  endtask

  // Drive now, compare just after the next rising edge.
  task automatic drive_chk(logic v, logic b, logic c, exp_t e);
    exp_t got;
    in_valid = v;
    in       = b;
    clear    = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    compare(got);
  endtask

  task automatic step(logic v, logic b, logic c, exp_t e);
    @(negedge clk);
    drive_chk(v, b, c, e);
  endtask

  function automatic void add(logic v, logic b, logic c, int sa, int ca, int xa,
                              int sb, int cb, string nm);
    vec_t r;
    r.v = v; r.b = b; r.c = c;
    r.e = '{sa, ca, xa, sb, cb, nm};
    tbl.push_back(r);
  endfunction

  function automatic void gap(int sa, int sb, int ca, int cb);
    add(1'b0, 1'b1, 1'b0, sa, ca, 0, sb, cb, "gap");
    add(1'b0, 1'b0, 1'b0, sa, ca, 0, sb, cb, "gap");
  endfunction

  // Longest suffix of the bit history that equals a pattern prefix.
  function automatic int pst(input bit h[$]);
    int best = 0;
    for (int j = 1; j <= PAT_W && j <= h.size(); j++) begin
      bit good = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (h[h.size() - j + i] != P[PAT_W - 1 - i]) good = 1'b0;
      end
      if (good) best = j;
    end
    return best;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in = 1'b0; in_valid = 1'b0; clear = 1'b0;
`ifdef MOORE_SEQ_PATTERN_LOAD_EN
    pat_load = 1'b0; pat_data = 4'b0000;
`endif

    // overlap / non-overlap stream 1,0,1,1,0,1,1
    add(1,1,0, 1,0,0, 1,0, "ov1");
    add(1,0,0, 2,0,0, 2,0, "ov2");
    add(1,1,0, 3,0,0, 3,0, "ov3");
    add(1,1,0, 4,1,0, 4,1, "ov4");
    add(1,0,0, 2,1,0, 0,1, "ov5");
    add(1,1,0, 3,1,0, 1,1, "ov6");
    add(1,1,0, 4,2,0, 1,1, "ov7");
    add(1,1,1, 0,0,0, 0,0, "clr_bit");
    // fallback with gaps: 1,0,1,0,1,1
    add(1,1,0, 1,0,0, 1,0, "fb1"); gap(1,1,0,0);
    add(1,0,0, 2,0,0, 2,0, "fb2"); gap(2,2,0,0);
    add(1,1,0, 3,0,0, 3,0, "fb3"); gap(3,3,0,0);
    add(1,0,0, 2,0,0, 2,0, "fb4"); gap(2,2,0,0);
    add(1,1,0, 3,0,0, 3,0, "fb5"); gap(3,3,0,0);
    add(1,1,0, 4,1,0, 4,1, "fb6");
    // drive A into saturation
    add(1,0,0, 2,1,0,  0,1, "s1");
    add(1,1,0, 3,1,0,  1,1, "s2");
    add(1,1,0, 4,2,0,  1,1, "s3");
    add(1,0,0, 2,2,0,  2,1, "s4");
    add(1,1,0, 3,2,0,  3,1, "s5");
    add(1,1,0, 4,3,-1, 4,2, "s6");
    add(1,0,0, 2,3,-1, 0,2, "s7");
    add(1,1,0, 3,3,-1, 1,2, "s8");
    add(1,1,0, 4,3,1,  1,2, "s9");
    add(1,0,1, 0,0,0,  0,0, "sat_clr");

    // reset held with bits toggling
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 1'b0, '{0,0,0,0,0,"rst_hold"});
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;

    foreach (tbl[i]) step(tbl[i].v, tbl[i].b, tbl[i].c, tbl[i].e);

    // asynchronous reset mid-match
    step(1,1,0, '{1,0,0,1,0,"mm1"});
    step(1,0,0, '{2,0,0,2,0,"mm2"});
    step(1,1,0, '{3,0,0,3,0,"mm3"});
    step(1,1,0, '{4,1,0,4,1,"mm4"});
    step(1,0,0, '{2,1,0,0,1,"mm5"});
    step(1,1,0, '{3,1,0,1,1,"mm6"});
    #1 reset = 1'b0;
    #1;
    compare('{0,0,0,0,0,"async_rst"});
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    step(1,1,0, '{1,0,0,1,0,"post_rst"});
    step(0,0,1, '{0,0,0,0,0,"clr2"});

    // random stream against a history model
    ma_s = 0; ma_c = 0; ma_x = 0; mb_s = 0; mb_c = 0;
    for (int n = 0; n < 300; n++) begin
      logic v, b, c;
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 31) == 0);
      if (c) begin
        ha.delete(); hb.delete();
        ma_s = 0; ma_c = 0; ma_x = 0; mb_s = 0; mb_c = 0;
      end else if (v) begin
        ha.push_back(b);
        if (ha.size() > PAT_W) void'(ha.pop_front());
        ma_s = pst(ha);
        if (ma_s == 4) begin
          if (ma_c == 3) ma_x = 1; else ma_c++;
        end
        if (mb_s == 4) hb.delete();
        hb.push_back(b);
        if (hb.size() > PAT_W) void'(hb.pop_front());
        mb_s = pst(hb);
        if (mb_s == 4) mb_c++;
      end
      step(v, b, c, '{ma_s, ma_c, ma_x, mb_s, mb_c, "rand"});
    end

`ifdef MOORE_SEQ_PATTERN_LOAD_EN
    step(0,0,1, '{0,0,0,0,0,"ld_clr"});
    step(1,1,0, '{1,0,0,1,0,"ld1"});
    step(1,0,0, '{2,0,0,2,0,"ld2"});
    step(1,1,0, '{3,0,0,3,0,"ld3"});
    step(1,1,0, '{4,1,0,4,1,"ld4"});
    step(1,0,0, '{2,1,0,0,1,"ld5"});
    @(negedge clk);
    pat_load = 1'b1; pat_data = 4'b0110;
    drive_chk(1'b1, 1'b1, 1'b0, '{0,1,0,0,1,"load"});
    pat_load = 1'b0;
    step(1,0,0, '{1,1,0,1,1,"np1"});
    step(1,1,0, '{2,1,0,2,1,"np2"});
    step(1,1,0, '{3,1,0,3,1,"np3"});
    step(1,0,0, '{4,2,0,4,2,"np4"});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
